// File: rtl/rf_write_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_queue_if
// Brief    : Producer, register-file write port and bypass bundle for
//            rf_write_queue.
// Revision : 1.0 - initial release
// ============================================================================
interface rf_write_queue_if;
    logic        a_valid;
    logic [3:0]  a_reg;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [3:0]  b_reg;
    logic [15:0] b_data;
    logic        b_ready;
    logic        WriteReg;
    logic [3:0]  DstReg;
    logic [15:0] DstData;
    logic [3:0]  SrcReg1;
    logic [3:0]  SrcReg2;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [15:0] byp_data1;
    logic [15:0] byp_data2;
    logic        idle;

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, SrcReg1, SrcReg2,
        output a_ready, b_ready, WriteReg, DstReg, DstData,
               byp_hit1, byp_hit2, byp_data1, byp_data2, idle
    );

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data, SrcReg1, SrcReg2,
        input  a_ready, b_ready, WriteReg, DstReg, DstData,
               byp_hit1, byp_hit2, byp_data1, byp_data2, idle
    );
endinterface
`default_nettype wire

// File: rtl/rf_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_queue
// Brief    : Two-producer in-order write queue feeding the register file's
//            single write port, with a combinational bypass lookup.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_queue #(
    parameter int DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rf_write_queue_if.slave    bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_LIM1 = c_CNT_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_LIM2 = c_CNT_W'(DEPTH - 2);

    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_CNT_W-1:0] r_count;
    logic [3:0]         r_memReg  [DEPTH];
    logic [15:0]        r_memData [DEPTH];
    logic               r_writeReg;
    logic [3:0]         r_dstReg;
    logic [15:0]        r_dstData;

    logic               w_aReady;
    logic               w_bReady;
    logic               w_aPush;
    logic               w_bPush;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_bIdx;
    logic [c_PTR_W-1:0] w_slotIdx [DEPTH];
    logic               w_slotVld [DEPTH];
    logic               w_hit1;
    logic               w_hit2;
    logic [15:0]        w_data1;
    logic [15:0]        w_data2;

    // Ready looks only at the registered count, never at this cycle's pop.
    assign w_aReady = (r_count <= c_LIM1);
    assign w_bReady = bus.a_valid ? (r_count <= c_LIM2) : (r_count <= c_LIM1);

    // Register-0 writes complete the handshake but are dropped here.
    assign w_aPush = bus.a_valid && w_aReady && (bus.a_reg != 4'd0);
    assign w_bPush = bus.b_valid && w_bReady && (bus.b_reg != 4'd0);
    assign w_pop   = (r_count != '0);
    assign w_bIdx  = r_wrPtr + c_PTR_W'(w_aPush);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_writeReg <= 1'b0;
            r_dstReg   <= '0;
            r_dstData  <= '0;
        end else begin
            r_wrPtr    <= r_wrPtr + c_PTR_W'(w_aPush) + c_PTR_W'(w_bPush);
            r_count    <= r_count + c_CNT_W'(w_aPush) + c_CNT_W'(w_bPush)
                          - c_CNT_W'(w_pop);
            r_writeReg <= w_pop;
            if (w_pop) begin
                r_rdPtr   <= r_rdPtr + c_PTR_W'(1);
                r_dstReg  <= r_memReg[r_rdPtr];
                r_dstData <= r_memData[r_rdPtr];
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_aPush) begin
            r_memReg[r_wrPtr]  <= bus.a_reg;
            r_memData[r_wrPtr] <= bus.a_data;
        end
        if (w_bPush) begin
            r_memReg[w_bIdx]  <= bus.b_reg;
            r_memData[w_bIdx] <= bus.b_data;
        end
    end

    // Slot i is the i-th oldest entry counted from the head.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign w_slotIdx[i] = r_rdPtr + c_PTR_W'(i);
        assign w_slotVld[i] = (c_CNT_W'(i) < r_count);
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_hit1  = 1'b0;
        w_hit2  = 1'b0;
        w_data1 = '0;
        w_data2 = '0;
        if (r_writeReg && (r_dstReg == bus.SrcReg1)) begin
            w_hit1  = 1'b1;
            w_data1 = r_dstData;
        end
        if (r_writeReg && (r_dstReg == bus.SrcReg2)) begin
            w_hit2  = 1'b1;
            w_data2 = r_dstData;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slotVld[i] && (r_memReg[w_slotIdx[i]] == bus.SrcReg1)) begin
                w_hit1  = 1'b1;
                w_data1 = r_memData[w_slotIdx[i]];
            end
            if (w_slotVld[i] && (r_memReg[w_slotIdx[i]] == bus.SrcReg2)) begin
                w_hit2  = 1'b1;
                w_data2 = r_memData[w_slotIdx[i]];
            end
        end
        if (bus.SrcReg1 == 4'd0) begin
            w_hit1  = 1'b0;
            w_data1 = '0;
        end
        if (bus.SrcReg2 == 4'd0) begin
            w_hit2  = 1'b0;
            w_data2 = '0;
        end
    end

    assign bus.a_ready   = w_aReady;
    assign bus.b_ready   = w_bReady;
    assign bus.WriteReg  = r_writeReg;
    assign bus.DstReg    = r_dstReg;
    assign bus.DstData   = r_dstData;
    assign bus.byp_hit1  = w_hit1;
    assign bus.byp_hit2  = w_hit2;
    assign bus.byp_data1 = w_data1;
    assign bus.byp_data2 = w_data2;
    assign bus.idle      = (r_count == '0) && !r_writeReg;

endmodule
`default_nettype wire

// File: doc/rf_write_queue.md
# rf_write_queue

Write-side initiator for the 16x16-bit register file. It accepts register writes from two producers, the ALU result path (port A) and the load/memory result path (port B). Accepted writes are buffered in a 4-entry in-order queue and issued one per cycle on the register file's single write port (`WriteReg`/`DstReg`/`DstData`). It also provides a bypass lookup, so the read side can see pending writes that have not yet reached the array. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- `DEPTH`, default 4: queue entries. Must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  port A (ALU) write request.
- `a_reg`  in  4  port A destination register.
- `a_data`  in  16  port A write data.
- `a_ready`  out  1  port A can accept this cycle.
- `b_valid`  in  1  port B (load) write request.
- `b_reg`  in  4  port B destination register.
- `b_data`  in  16  port B write data.
- `b_ready`  out  1  port B can accept this cycle.
- `WriteReg`  out  1  register file write enable (registered).
- `DstReg`  out  4  register file write index (registered).
- `DstData`  out  16  register file write data (registered).
- `SrcReg1`, `SrcReg2`  in  4 each  read-port indices to look up.
- `byp_hit1`, `byp_hit2`  out  1 each  a pending write exists for `SrcReg1`/`SrcReg2`.
- `byp_data1`, `byp_data2`  out  16 each  youngest pending data for that register. Value is 0 when there is no hit.
- `idle`  out  1  queue empty and `WriteReg`=0.

## Operation
- Queue: circular buffer with `wr_ptr`, `rd_ptr` (log2 DEPTH bits, wrap modulo DEPTH) and `count` (0..DEPTH, log2 DEPTH+1 bits).
- Ready is computed from the registered `count` only. It does not depend on a same-cycle pop.
  - `a_ready` = (count <= DEPTH-1).
  - `b_ready` = a_valid ? (count <= DEPTH-2) : (count <= DEPTH-1).
- A transfer occurs on a port when valid && ready.
- Simultaneous A and B transfers: A is enqueued first (older), then B. Write order into the array follows enqueue order.
- Writes to register 0:
  - The transfer completes normally (ready honoured).
  - The entry is not enqueued and `count` is unchanged.
  - It never appears on the write port.
- Issue: each cycle, if count > 0, the head is popped into the output registers with `WriteReg`=1, `DstReg`/`DstData` taken from the entry. If count = 0, `WriteReg`=0 and `DstReg`/`DstData` hold their previous values.
- Push and pop in the same cycle are both applied. `count` next = count + pushes − pop.
- Bypass is combinational.
  - Search scope: all valid queue entries plus the output stage (when `WriteReg`=1).
  - Priority: youngest queue entry, then older entries, with the output stage as oldest.
  - `SrcRegN`=0 never hits.
  - Same-cycle incoming requests are not searched.

## Timing
- Reset values: `WriteReg`=0, `DstReg`=0, `DstData`=0, count=0, both pointers 0. Queue contents are don't-care.
- Reset-derived outputs: `a_ready`=1, `b_ready`=1, `idle`=1, `byp_hit*`=0.
- Reset mid-operation: all pending writes are discarded. `WriteReg` is 0 in the cycle after the reset edge.
- Latency, with an empty queue:
  - Request accepted at edge N.
  - `WriteReg`=1 with that entry during cycle N+1 (after edge N+1).
  - Register file updates at edge N+2.
- Throughput: one issued write per cycle and up to two accepted per cycle. A sustained two-per-cycle stream fills the queue, then ready throttles.
- Full: count=DEPTH gives `a_ready`=0 and `b_ready`=0. A pop that cycle does not raise ready until the next cycle.
- Empty: no pop occurs and `WriteReg` deasserts in the following cycle.
- Pointer wrap from DEPTH-1 to 0 must preserve FIFO order.
- Bypass data is valid in the same cycle as `SrcRegN`. An entry is visible from the cycle after its acceptance until the cycle after its `WriteReg` pulse.

## Test plan
- Reset then idle:
  - Stimulus: assert `rst` for 2 cycles with no requests.
  - Required response: `WriteReg`=0, `DstReg`=0, `DstData`=0, `a_ready`=`b_ready`=1 and `idle`=1 throughout.
- Single write latency:
  - Stimulus: A writes R3=0x1234 at edge N.
  - Required response: cycle N+1 shows `WriteReg`=1, `DstReg`=3, `DstData`=0x1234. Cycle N+2 shows `WriteReg`=0 and `idle`=1.
- Dual accept ordering:
  - Stimulus: in one cycle A writes R5=0x00AA and B writes R5=0x00BB.
  - Required response: issue order R5/0x00AA then R5/0x00BB. `byp_data` for `SrcReg1`=5 is 0x00BB while both are pending.
- Full and wrap:
  - Stimulus: hold A and B valid with distinct registers R1..R15 for 6 cycles.
  - Required response:
    - `b_ready` drops when count=3.
    - Both ready signals drop when count=4.
    - Issued sequence matches acceptance order across a pointer wrap, with no loss or duplicate.
- R0 and bypass:
  - Stimulus: A writes R0=0xFFFF, then R7=0x0042.
  - Required response:
    - R0 is never issued.
    - `SrcReg2`=0 gives `byp_hit2`=0.
    - `SrcReg2`=7 gives `byp_hit2`=1 with `byp_data2`=0x0042 until the cycle after its issue.
- Reset mid-operation:
  - Stimulus: with 3 pending writes, assert `rst` for 1 cycle.
  - Required response: none of the pending writes issue after the reset edge, and count=0.
